// File: rtl/usb_bus_state_ctrl_if.sv
// Bus-side signal bundle of the USB bus-state controller.
// The controller takes the slave view; the device core or a testbench takes the master view.
interface usb_bus_state_ctrl_if;
    logic usb_p_rx;
    logic usb_n_rx;
    logic wake_req;
    logic wake_ack;
    logic usb_reset;
    logic suspend;
    logic resume;
    logic usb_tx_en;
    logic usb_p_tx;
    logic usb_n_tx;

    modport slave (
        input  usb_p_rx,
        input  usb_n_rx,
        input  wake_req,
        output wake_ack,
        output usb_reset,
        output suspend,
        output resume,
        output usb_tx_en,
        output usb_p_tx,
        output usb_n_tx
    );

    modport master (
        output usb_p_rx,
        output usb_n_rx,
        output wake_req,
        input  wake_ack,
        input  usb_reset,
        input  suspend,
        input  resume,
        input  usb_tx_en,
        input  usb_p_tx,
        input  usb_n_tx
    );
endinterface

// File: rtl/usb_bus_state_ctrl.sv
// Full-speed USB bus-state controller: line classification, bus reset, suspend,
// host resume and device remote wakeup sequencing.
module usb_bus_state_ctrl #(
    parameter int unsigned RESET_CYCLES      = 30000,
    parameter int unsigned SUSPEND_CYCLES    = 144000,
    parameter int unsigned WAKE_IDLE_CYCLES  = 240000,
    parameter int unsigned WAKE_DRIVE_CYCLES = 48000,
    parameter int unsigned CNT_W             = 18
) (
    input  logic                 clk,
    input  logic                 reset_n,
    usb_bus_state_ctrl_if.slave  bus
);

    localparam logic [1:0] LineSe0 = 2'b00;
    localparam logic [1:0] LineK   = 2'b01;
    localparam logic [1:0] LineJ   = 2'b10;

    localparam logic [CNT_W-1:0] ResetThr   = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] SuspendThr = CNT_W'(SUSPEND_CYCLES);
    localparam logic [CNT_W-1:0] WakeIdle   = CNT_W'(WAKE_IDLE_CYCLES);
    localparam logic [CNT_W-1:0] DriveLast  = CNT_W'(WAKE_DRIVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax     = '1;

    typedef enum logic [2:0] {
        StActive,
        StBusReset,
        StSuspended,
        StRemoteWake,
        StResuming
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [1:0]       r_line;
    logic [1:0]       w_line;
    logic [CNT_W-1:0] r_line_cnt;
    logic [CNT_W-1:0] w_line_cnt_nxt;
    logic [CNT_W-1:0] r_sus_cnt;
    logic [CNT_W-1:0] w_sus_cnt_nxt;
    logic             r_resume;
    logic             w_resume_nxt;
    logic             w_ack;
    logic             w_reset_thr;
    logic             w_idle_thr;
    logic             w_smp_se0;
    logic             w_smp_k;
    logic             w_smp_j;
    logic             w_wake_ok;

    assign w_line    = {bus.usb_p_rx, bus.usb_n_rx};
    assign w_smp_se0 = (w_line == LineSe0);
    assign w_smp_k   = (w_line == LineK);
    assign w_smp_j   = (w_line == LineJ);

    // Long-run thresholds come from the registered line and its run length; single-sample
    // exits (K, J, non-SE0) act on the sample being taken at this edge.
    assign w_reset_thr = (r_line == LineSe0) && (r_line_cnt >= ResetThr);
    assign w_idle_thr  = (r_line == LineJ) && (r_line_cnt >= SuspendThr);
    assign w_wake_ok   = bus.wake_req && (r_sus_cnt >= WakeIdle);

    always_comb begin
        w_line_cnt_nxt = CntOne;
        if (w_line == r_line) begin
            w_line_cnt_nxt = (r_line_cnt == CntMax) ? r_line_cnt : r_line_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ack        = 1'b0;
        w_resume_nxt = 1'b0;
        unique case (r_state)
            StActive: begin
                if (w_reset_thr) begin
                    w_state_nxt = StBusReset;
                end else if (w_idle_thr) begin
                    w_state_nxt = StSuspended;
                end
            end
            StBusReset: begin
                if (!w_smp_se0) begin
                    w_state_nxt = StActive;
                end
            end
            StSuspended: begin
                if (w_reset_thr) begin
                    w_state_nxt = StBusReset;
                end else if (w_smp_k) begin
                    w_state_nxt = StResuming;
                end else if (w_wake_ok) begin
                    w_state_nxt = StRemoteWake;
                    w_ack       = 1'b1;
                end
            end
            StRemoteWake: begin
                if (r_sus_cnt >= DriveLast) begin
                    w_state_nxt = StResuming;
                end
            end
            StResuming: begin
                if (w_reset_thr) begin
                    w_state_nxt = StBusReset;
                end else if (w_smp_j) begin
                    w_state_nxt  = StActive;
                    w_resume_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = StActive;
            end
        endcase
    end

    // sus_cnt times both the idle period and the K drive; it restarts on every state change.
    always_comb begin
        w_sus_cnt_nxt = '0;
        if ((w_state_nxt == r_state)
            && ((r_state == StSuspended) || (r_state == StRemoteWake))) begin
            w_sus_cnt_nxt = (r_sus_cnt == CntMax) ? r_sus_cnt : r_sus_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= StActive;
            r_line     <= LineJ;
            r_line_cnt <= '0;
            r_sus_cnt  <= '0;
            r_resume   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_line     <= w_line;
            r_line_cnt <= w_line_cnt_nxt;
            r_sus_cnt  <= w_sus_cnt_nxt;
            r_resume   <= w_resume_nxt;
        end
    end

    assign bus.wake_ack  = w_ack & reset_n;
    assign bus.usb_reset = (r_state == StBusReset);
    assign bus.suspend   = (r_state == StSuspended) || (r_state == StRemoteWake)
                           || (r_state == StResuming);
    assign bus.resume    = r_resume;
    assign bus.usb_tx_en = (r_state == StRemoteWake);
    assign bus.usb_p_tx  = 1'b0;
    assign bus.usb_n_tx  = (r_state == StRemoteWake);

endmodule

// File: tb/tb_usb_bus_state_ctrl.sv
// Directed and randomized bench for usb_bus_state_ctrl against a timestamp-based bus model.
module tb_usb_bus_state_ctrl;

    localparam int R = 16;
    localparam int S = 32;
    localparam int I = 40;
    localparam int D = 8;

    localparam int CSe0 = 0;
    localparam int CK   = 1;
    localparam int CJ   = 2;
    localparam int CSe1 = 3;

    logic clk;
    logic reset_n;

    usb_bus_state_ctrl_if bus_if ();

    usb_bus_state_ctrl #(
        .RESET_CYCLES      (R),
        .SUSPEND_CYCLES    (S),
        .WAKE_IDLE_CYCLES  (I),
        .WAKE_DRIVE_CYCLES (D),
        .CNT_W             (18)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    // Reference: what the bus looked like (sample history) and when phases began.
    typedef enum int {MIdleBus, MInReset, MAsleep, MSignalling, MWaitHost} phase_t;
    phase_t m_phase;
    int     hist[$];
    int     m_cyc;
    int     m_sleep_at;
    int     m_drive_at;
    bit     m_resume;

    function automatic int last_class();
        return (hist.size() == 0) ? CJ : hist[0];
    endfunction

    function automatic int run_len();
        int n;
        n = 0;
        while (n < hist.size() && hist[n] == hist[0]) n++;
        return n;
    endfunction

    function automatic int pin_class();
        return {30'd0, bus_if.usb_p_rx, bus_if.usb_n_rx};
    endfunction

    function automatic bit long_se0();
        return last_class() == CSe0 && run_len() >= R;
    endfunction

    function automatic bit exp_ack();
        return reset_n && m_phase == MAsleep && !long_se0() && pin_class() != CK
               && bus_if.wake_req && (m_cyc - m_sleep_at) >= I;
    endfunction

    task automatic model_update();
        int c;
        c = pin_class();
        m_resume = 1'b0;
        if (!reset_n) begin
            hist.delete();
            m_phase = MIdleBus;
        end else begin
            case (m_phase)
                MIdleBus: begin
                    if (long_se0()) m_phase = MInReset;
                    else if (last_class() == CJ && run_len() >= S) begin
                        m_phase    = MAsleep;
                        m_sleep_at = m_cyc + 1;
                    end
                end
                MInReset: if (c != CSe0) m_phase = MIdleBus;
                MAsleep: begin
                    if (long_se0()) m_phase = MInReset;
                    else if (c == CK) m_phase = MWaitHost;
                    else if (bus_if.wake_req && (m_cyc - m_sleep_at) >= I) begin
                        m_phase    = MSignalling;
                        m_drive_at = m_cyc + 1;
                    end
                end
                MSignalling: if (m_cyc - m_drive_at + 1 >= D) m_phase = MWaitHost;
                MWaitHost: begin
                    if (long_se0()) m_phase = MInReset;
                    else if (c == CJ) begin
                        m_phase  = MIdleBus;
                        m_resume = 1'b1;
                    end
                end
                default: m_phase = MIdleBus;
            endcase
            hist.push_front(c);
            if (hist.size() > 64) void'(hist.pop_back());
        end
        m_cyc++;
    endtask

    task automatic check(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s at cycle %0d: observed %b expected %b", tag, m_cyc, obs, expv);
        end
    endtask

    task automatic compare_model();
        bit drv;
        drv = (m_phase == MSignalling);
        check("m_usb_reset", bus_if.usb_reset, m_phase == MInReset);
        check("m_suspend", bus_if.suspend,
              m_phase == MAsleep || m_phase == MSignalling || m_phase == MWaitHost);
        check("m_resume", bus_if.resume, m_resume);
        check("m_wake_ack", bus_if.wake_ack, exp_ack());
        check("m_tx_en", bus_if.usb_tx_en, drv);
        check("m_p_tx", bus_if.usb_p_tx, 1'b0);
        check("m_n_tx", bus_if.usb_n_tx, drv);
    endtask

    task automatic step();
        @(negedge clk);
        compare_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drive(input int cls, input bit wr);
        {bus_if.usb_p_rx, bus_if.usb_n_rx} = cls[1:0];
        bus_if.wake_req = wr;
    endtask

    task automatic go_suspend(input bit wr);
        drive(CK, wr);
        steps(1);
        drive(CJ, wr);
        steps(S + 1);
    endtask

    int r;
    int cls;
    int len;

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        m_cyc      = 0;
        m_sleep_at = 0;
        m_drive_at = 0;
        m_resume   = 1'b0;
        m_phase    = MIdleBus;
        reset_n    = 1'b0;
        drive(CJ, 1'b0);
        repeat (3) begin
            @(posedge clk);
            model_update();
        end
        #1;
        check("rst_usb_reset", bus_if.usb_reset, 1'b0);
        check("rst_suspend", bus_if.suspend, 1'b0);
        check("rst_resume", bus_if.resume, 1'b0);
        check("rst_wake_ack", bus_if.wake_ack, 1'b0);
        check("rst_tx_en", bus_if.usb_tx_en, 1'b0);
        check("rst_p_tx", bus_if.usb_p_tx, 1'b0);
        check("rst_n_tx", bus_if.usb_n_tx, 1'b0);
        reset_n = 1'b1;

        // Bus reset detect and release
        drive(CJ, 1'b0);
        steps(10);
        drive(CSe0, 1'b0);
        steps(R);
        check("busrst_before", bus_if.usb_reset, 1'b0);
        steps(1);
        check("busrst_rise", bus_if.usb_reset, 1'b1);
        steps(3);
        drive(CJ, 1'b0);
        check("busrst_hold", bus_if.usb_reset, 1'b1);
        steps(1);
        check("busrst_fall", bus_if.usb_reset, 1'b0);
        steps(5);
        drive(CSe0, 1'b0);
        steps(R - 1);
        drive(CJ, 1'b0);
        steps(3);
        check("short_se0", bus_if.usb_reset, 1'b0);

        // Suspend and host resume
        drive(CK, 1'b0);
        steps(1);
        drive(CJ, 1'b0);
        steps(S);
        check("susp_before", bus_if.suspend, 1'b0);
        steps(1);
        check("susp_rise", bus_if.suspend, 1'b1);
        steps(7);
        drive(CK, 1'b0);
        steps(1);
        check("host_k_susp", bus_if.suspend, 1'b1);
        steps(19);
        drive(CSe0, 1'b0);
        steps(2);
        check("eop_stays", bus_if.suspend, 1'b1);
        drive(CJ, 1'b0);
        check("resume_pre", bus_if.resume, 1'b0);
        steps(1);
        check("resume_pulse", bus_if.resume, 1'b1);
        check("resume_susp", bus_if.suspend, 1'b0);
        steps(1);
        check("resume_once", bus_if.resume, 1'b0);

        // Remote wakeup
        go_suspend(1'b0);
        check("rw_susp", bus_if.suspend, 1'b1);
        drive(CJ, 1'b1);
        steps(I - 1);
        check("rw_ack_early", bus_if.wake_ack, 1'b0);
        steps(1);
        check("rw_ack", bus_if.wake_ack, 1'b1);
        check("rw_tx_pre", bus_if.usb_tx_en, 1'b0);
        steps(1);
        check("rw_ack_once", bus_if.wake_ack, 1'b0);
        check("rw_tx_en", bus_if.usb_tx_en, 1'b1);
        check("rw_p_tx", bus_if.usb_p_tx, 1'b0);
        check("rw_n_tx", bus_if.usb_n_tx, 1'b1);
        drive(CK, 1'b0);
        steps(D - 1);
        check("rw_tx_last", bus_if.usb_tx_en, 1'b1);
        steps(1);
        check("rw_tx_done", bus_if.usb_tx_en, 1'b0);
        check("rw_resuming", bus_if.suspend, 1'b1);
        drive(CJ, 1'b0);
        steps(1);
        check("rw_resume", bus_if.resume, 1'b1);
        check("rw_active", bus_if.suspend, 1'b0);

        // Early wake request, then reset during the K drive
        drive(CK, 1'b1);
        steps(5);
        check("early_ack_active", bus_if.wake_ack, 1'b0);
        go_suspend(1'b1);
        steps(10);
        check("early_ack_s10", bus_if.wake_ack, 1'b0);
        check("early_tx_s10", bus_if.usb_tx_en, 1'b0);
        steps(I - 11);
        check("early_ack_s39", bus_if.wake_ack, 1'b0);
        steps(1);
        check("early_ack_s40", bus_if.wake_ack, 1'b1);
        steps(4);
        check("drive_c3", bus_if.usb_tx_en, 1'b1);
        reset_n = 1'b0;
        drive(CJ, 1'b0);
        steps(1);
        check("midrst_tx_en", bus_if.usb_tx_en, 1'b0);
        check("midrst_n_tx", bus_if.usb_n_tx, 1'b0);
        check("midrst_susp", bus_if.suspend, 1'b0);
        check("midrst_usb_reset", bus_if.usb_reset, 1'b0);
        reset_n = 1'b1;

        // Coincident K and eligible wake; SE0 reset out of suspend
        go_suspend(1'b0);
        steps(I + 5);
        drive(CK, 1'b1);
        #1;
        check("coinc_ack", bus_if.wake_ack, 1'b0);
        steps(1);
        check("coinc_resuming", bus_if.suspend, 1'b1);
        check("coinc_tx", bus_if.usb_tx_en, 1'b0);
        drive(CJ, 1'b0);
        steps(1);
        go_suspend(1'b0);
        drive(CSe0, 1'b0);
        steps(R);
        check("sus_se0_before", bus_if.usb_reset, 1'b0);
        steps(1);
        check("sus_se0_reset", bus_if.usb_reset, 1'b1);
        check("sus_se0_susp", bus_if.suspend, 1'b0);
        drive(CJ, 1'b0);
        steps(2);

        // Randomized runs of line states, wake requests and occasional resets
        for (int seg = 0; seg < 150; seg++) begin
            r = $urandom_range(0, 9);
            if (r < 5) cls = CJ;
            else if (r < 7) cls = CK;
            else if (r < 9) cls = CSe0;
            else cls = CSe1;
            len = (cls == CJ) ? $urandom_range(1, 110) : $urandom_range(1, 24);
            drive(cls, $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) reset_n = 1'b0;
            for (int i = 0; i < len; i++) begin
                step();
                reset_n = 1'b1;
                if ($urandom_range(0, 15) == 0) bus_if.wake_req = ~bus_if.wake_req;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
